// File: rtl/axi4_lite_master_cmd.sv
// AXI4-Lite initiator driven by a single-beat command/response handshake.
// A host command (read or write) is turned into one AXI4-Lite transaction, and
// the captured slave response is returned on the response channel. Only one
// transaction is outstanding at a time. A sticky flag reports transactions
// that have waited TIMEOUT_CYCLES cycles on the slave; 0 disables it.
//
// Ports:
//   m00_axi_aclk, m00_axi_areset   clock, asynchronous active-high reset
//   i_cmd_*/o_cmd_ready            command request channel
//   o_rsp_*/i_rsp_ready            response channel (rdata is 0 for writes)
//   o_timeout, i_timeout_clr       sticky timeout flag and its clear
//   m00_axi_*                      AXI4-Lite master interface
module axi4_lite_master_cmd #(
  parameter int unsigned C_M00_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_M00_AXI_ADDR_WIDTH = 5,
  parameter int unsigned TIMEOUT_CYCLES       = 1024
) (
  input  logic                              m00_axi_aclk,
  input  logic                              m00_axi_areset,
  // Command channel
  input  logic                              i_cmd_valid,
  output logic                              o_cmd_ready,
  input  logic                              i_cmd_write,
  input  logic [C_M00_AXI_ADDR_WIDTH-1:0]   i_cmd_addr,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0]   i_cmd_wdata,
  input  logic [C_M00_AXI_DATA_WIDTH/8-1:0] i_cmd_wstrb,
  // Response channel
  output logic                              o_rsp_valid,
  input  logic                              i_rsp_ready,
  output logic [C_M00_AXI_DATA_WIDTH-1:0]   o_rsp_rdata,
  output logic [1:0]                        o_rsp_resp,
  output logic                              o_rsp_write,
  // Timeout
  output logic                              o_timeout,
  input  logic                              i_timeout_clr,
  // AXI4-Lite write address
  output logic [C_M00_AXI_ADDR_WIDTH-1:0]   m00_axi_awaddr,
  output logic [2:0]                        m00_axi_awprot,
  output logic                              m00_axi_awvalid,
  input  logic                              m00_axi_awready,
  // AXI4-Lite write data
  output logic [C_M00_AXI_DATA_WIDTH-1:0]   m00_axi_wdata,
  output logic [C_M00_AXI_DATA_WIDTH/8-1:0] m00_axi_wstrb,
  output logic                              m00_axi_wvalid,
  input  logic                              m00_axi_wready,
  // AXI4-Lite write response
  input  logic [1:0]                        m00_axi_bresp,
  input  logic                              m00_axi_bvalid,
  output logic                              m00_axi_bready,
  // AXI4-Lite read address
  output logic [C_M00_AXI_ADDR_WIDTH-1:0]   m00_axi_araddr,
  output logic [2:0]                        m00_axi_arprot,
  output logic                              m00_axi_arvalid,
  input  logic                              m00_axi_arready,
  // AXI4-Lite read data
  input  logic [C_M00_AXI_DATA_WIDTH-1:0]   m00_axi_rdata,
  input  logic [1:0]                        m00_axi_rresp,
  input  logic                              m00_axi_rvalid,
  output logic                              m00_axi_rready
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StBresp,
    StRead,
    StRdata,
    StRsp
  } state_e;

  state_e                              state_q;
  logic                                cmd_ready_q;
  logic [C_M00_AXI_ADDR_WIDTH-1:0]     addr_q;
  logic [C_M00_AXI_DATA_WIDTH-1:0]     wdata_q;
  logic [C_M00_AXI_DATA_WIDTH/8-1:0]   wstrb_q;
  logic                                awvalid_q;
  logic                                wvalid_q;
  logic                                bready_q;
  logic                                arvalid_q;
  logic                                rready_q;
  logic                                rsp_valid_q;
  logic [C_M00_AXI_DATA_WIDTH-1:0]     rsp_rdata_q;
  logic [1:0]                          rsp_resp_q;
  logic                                rsp_write_q;
  logic                                timeout_q;
  logic [CntW-1:0]                     cnt_q;

  logic cmd_accept;
  logic in_wait;
  logic cnt_sat;
  logic timeout_set;
  logic aw_done;
  logic w_done;

  assign cmd_accept = i_cmd_valid && cmd_ready_q;
  assign in_wait    = (state_q == StWrite) || (state_q == StBresp) ||
                      (state_q == StRead)  || (state_q == StRdata);
  // With TIMEOUT_CYCLES == 0 the limit is 0, so the counter is born saturated.
  assign cnt_sat    = (cnt_q == CntW'(TIMEOUT_CYCLES));
  // Fire only on the cycle the counter reaches the limit, so a clear sticks
  // while the same transaction keeps waiting.
  assign timeout_set = (TIMEOUT_CYCLES != 0) && in_wait && !cnt_sat &&
                       ((cnt_q + CntW'(1)) == CntW'(TIMEOUT_CYCLES));

  // Each write channel is done once its valid has been accepted.
  assign aw_done = !awvalid_q || m00_axi_awready;
  assign w_done  = !wvalid_q  || m00_axi_wready;

  always_ff @(posedge m00_axi_aclk or posedge m00_axi_areset) begin
    if (m00_axi_areset) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
      rsp_write_q <= 1'b0;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      // Wait counter and sticky flag; a simultaneous set beats the clear.
      if (cmd_accept) begin
        cnt_q <= '0;
      end else if (in_wait && !cnt_sat) begin
        cnt_q <= cnt_q + CntW'(1);
      end
      if (timeout_set) begin
        timeout_q <= 1'b1;
      end else if (i_timeout_clr) begin
        timeout_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (cmd_accept) begin
            cmd_ready_q <= 1'b0;
            addr_q      <= i_cmd_addr;
            wdata_q     <= i_cmd_wdata;
            wstrb_q     <= i_cmd_wstrb;
            if (i_cmd_write) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= StWrite;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= StRead;
            end
          end
        end
        StWrite: begin
          if (m00_axi_awready) awvalid_q <= 1'b0;
          if (m00_axi_wready)  wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state_q  <= StBresp;
          end
        end
        StBresp: begin
          if (m00_axi_bvalid) begin
            bready_q    <= 1'b0;
            rsp_resp_q  <= m00_axi_bresp;
            rsp_rdata_q <= '0;
            rsp_write_q <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= StRsp;
          end
        end
        StRead: begin
          if (m00_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= StRdata;
          end
        end
        StRdata: begin
          if (m00_axi_rvalid) begin
            rready_q    <= 1'b0;
            rsp_resp_q  <= m00_axi_rresp;
            rsp_rdata_q <= m00_axi_rdata;
            rsp_write_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= StRsp;
          end
        end
        StRsp: begin
          if (i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q     <= StIdle;
          cmd_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign o_cmd_ready     = cmd_ready_q;
  assign o_rsp_valid     = rsp_valid_q;
  assign o_rsp_rdata     = rsp_rdata_q;
  assign o_rsp_resp      = rsp_resp_q;
  assign o_rsp_write     = rsp_write_q;
  assign o_timeout       = timeout_q;
  assign m00_axi_awaddr  = addr_q;
  assign m00_axi_awprot  = 3'b000;
  assign m00_axi_awvalid = awvalid_q;
  assign m00_axi_wdata   = wdata_q;
  assign m00_axi_wstrb   = wstrb_q;
  assign m00_axi_wvalid  = wvalid_q;
  assign m00_axi_bready  = bready_q;
  assign m00_axi_araddr  = addr_q;
  assign m00_axi_arprot  = 3'b000;
  assign m00_axi_arvalid = arvalid_q;
  assign m00_axi_rready  = rready_q;

endmodule

// File: doc/axi4_lite_master_cmd.md
Name: axi4_lite_master_cmd

Overview:
- AXI4-Lite initiator that converts single-beat host commands into AXI4-Lite write or read transactions toward a register-slave peripheral, such as the RISC-V control IP.
- Used by the bench and by on-chip bring-up logic to load instructions and poll run, idle and done status without a processor.
- Handles one outstanding transaction at a time.
- Provides a response channel to the command issuer and a sticky timeout flag.

Parameters:
- C_M00_AXI_DATA_WIDTH, 32, AXI data width. Only 32 is supported.
- C_M00_AXI_ADDR_WIDTH, 5, AXI address width.
- TIMEOUT_CYCLES, 1024, number of cycles a transaction may wait before `o_timeout` sets. A value of 0 disables the timeout.

Ports:
- m00_axi_aclk  in  1  clock
- m00_axi_areset  in  1  reset
- i_cmd_valid  in  1  command request
- o_cmd_ready  out  1  command accepted when high with i_cmd_valid
- i_cmd_write  in  1  1 = write, 0 = read
- i_cmd_addr  in  ADDR_WIDTH  byte address
- i_cmd_wdata  in  DATA_WIDTH  write data
- i_cmd_wstrb  in  DATA_WIDTH/8  write strobes
- o_rsp_valid  out  1  response available
- i_rsp_ready  in  1  response consumed
- o_rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- o_rsp_resp  out  2  captured BRESP or RRESP
- o_rsp_write  out  1  echo of the command type
- o_timeout  out  1  sticky timeout flag
- i_timeout_clr  in  1  clears o_timeout
- m00_axi_awaddr/awprot/awvalid  out, m00_axi_awready  in
- m00_axi_wdata/wstrb/wvalid  out, m00_axi_wready  in
- m00_axi_bresp  in  2, m00_axi_bvalid  in, m00_axi_bready  out
- m00_axi_araddr/arprot/arvalid  out, m00_axi_arready  in
- m00_axi_rdata  in, m00_axi_rresp  in  2, m00_axi_rvalid  in, m00_axi_rready  out

Interface rule: one clock, m00_axi_aclk. Reset m00_axi_areset is asynchronous and active-high.

Behaviour:
- Reset: state IDLE. All *valid and *ready outputs are 0 except o_cmd_ready = 1. All address, data and response registers are 0. o_timeout = 0.
- Reset mid-transaction: all outputs drop to reset values immediately (asynchronous). Any pending slave response is not tracked.
- awprot and arprot are fixed at 3'b000. All AXI outputs come from registers; there are no combinational paths from input to output.
- **IDLE**
  - o_cmd_ready = 1.
  - On i_cmd_valid && o_cmd_ready, capture addr, wdata, wstrb and the command type.
  - A write goes to WRITE with awvalid = 1 and wvalid = 1 on the next cycle.
  - A read goes to READ with arvalid = 1 on the next cycle.
- **Outside IDLE:** o_cmd_ready = 0.
- **WRITE**
  - awvalid is held until an awready cycle, then cleared. wvalid is held independently until a wready cycle, then cleared.
  - Either handshake may occur first, or both in the same cycle.
  - When both handshakes are complete, go to BRESP with bready = 1.
- **BRESP**
  - On bvalid, capture bresp and set rdata = 0.
  - Clear bready and go to RSP.
- **READ**
  - arvalid is held until arready, then cleared and rready set.
  - Go to RDATA.
- **RDATA**
  - On rvalid, capture rdata and rresp.
  - Clear rready and go to RSP.
- **RSP**
  - o_rsp_valid = 1. Response fields stay stable until i_rsp_ready.
  - On i_rsp_ready, go to IDLE. o_cmd_ready is 1 on the following cycle.
- **AXI stability:** awaddr, wdata, wstrb and araddr never change while the corresponding valid is high. A valid is never withdrawn before its handshake, except by reset.
- **Minimum latency with an always-ready slave:**
  - Command accepted in cycle 0.
  - awvalid/wvalid handshake in cycle 1.
  - bready in cycle 2 while bvalid is high.
  - o_rsp_valid in cycle 3.
  - The read path has the same timing.
- **Timeout**
  - The wait counter is cleared on command acceptance and increments each cycle in WRITE, BRESP, READ or RDATA.
  - When the counter reaches TIMEOUT_CYCLES (nonzero), o_timeout sets. The counter saturates and the transaction continues to wait; there is no abort.
  - i_timeout_clr clears o_timeout. If set and clear occur in the same cycle, set wins.
- Slave responses SLVERR and DECERR are passed through unchanged in o_rsp_resp and do not set o_timeout.

Test Plan:
- Write addr 5'h14, data 32'hDEADBEEF, wstrb 4'hF, slave always ready, BRESP 00 -> awaddr = 14 and wdata = DEADBEEF for 1 cycle; o_rsp_valid in cycle 3 with resp 00, rdata 0, o_rsp_write 1.
- Write where wready arrives 3 cycles before awready, then the reverse order -> bready rises only after both handshakes; awaddr and wdata are stable while valid is high; each write gets exactly one response.
- Read addr 5'h08, arready delayed 2 cycles, rvalid with rdata 32'h00000007 and rresp 00 -> o_rsp_rdata = 7, o_rsp_write 0; rready is high only in RDATA.
- i_rsp_ready held low for 5 cycles while a second i_cmd_valid is pending -> response is stable, o_cmd_ready stays 0, and the second command is accepted one cycle after the response is consumed.
- TIMEOUT_CYCLES = 8, slave never asserts awready -> o_timeout = 1 after 8 wait cycles and awvalid stays 1. i_timeout_clr then clears the flag. Asserting m00_axi_areset mid-wait drops awvalid asynchronously and returns o_cmd_ready = 1.
- Read returning rresp 2'b10 -> o_rsp_resp = 10 and o_timeout stays 0.
